// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: ALU opcodes and operand-entry sequencer states.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        ISSUE = 2'd2
    } alu_seq_state_t;

    // Switch entry is sign + 16-bit magnitude field, widened by sign replication.
    function automatic logic [31:0] sext_entry(input logic [16:0] sw);
        return {{16{sw[16]}}, sw[15:0]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, optional debounce (ALU_SEQ_DEBOUNCE_EN), press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_in,
    output logic press
);

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("btn_debounce: DB_CYCLES must be at least 1");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    // Counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level;
        end
    end

    // Both terms are flop outputs, so the pulse is glitch-free and lasts one cycle.
    assign press = level & ~level_prev_q;

endmodule

// File: rtl/alu_input_seq.sv
// rtl/alu_input_seq.sv - operand/op entry sequencer for the ALU; debounce via ALU_SEQ_DEBOUNCE_EN.
module alu_input_seq
    import cpu_types_pkg::*;
#(
    parameter int DB_CYCLES = 250000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [16:0] sw_data,
    input  aluop_t      op_in,
    input  logic        btn,
    input  logic        cancel,
    input  logic        ack,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output aluop_t      aluop_out,
    output logic        op_valid,
    output logic [1:0]  state_out,
    output logic [7:0]  issue_cnt
);

    logic press;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .CLK    (CLK),
        .RST    (RST),
        .btn_in (btn),
        .press  (press)
    );

    alu_seq_state_t state_q, state_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    aluop_t         op_q, op_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           valid_q;

    // Cancel overrides any press or ack seen in the same cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        if (cancel) begin
            state_d = GET_A;
        end else begin
            case (state_q)
                GET_A: begin
                    if (press) begin
                        a_d     = sext_entry(sw_data);
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (press) begin
                        b_d     = sext_entry(sw_data);
                        op_d    = op_in;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack) begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = GET_A;
                    end
                end
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == ISSUE);
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign aluop_out = op_q;
    assign op_valid  = valid_q;
    assign state_out = state_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// tb/tb_alu_input_seq.sv - self-checking bench for alu_input_seq (either ALU_SEQ_DEBOUNCE_EN build).
module tb_alu_input_seq;
    import cpu_types_pkg::*;

    localparam int DB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif
    localparam int HOLD = LAT + 1;
    localparam int REL  = LAT + 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [16:0] sw_data;
    aluop_t      op_in;
    logic        btn;
    logic        cancel;
    logic        ack;
    logic [31:0] a_out;
    logic [31:0] b_out;
    aluop_t      aluop_out;
    logic        op_valid;
    logic [1:0]  state_out;
    logic [7:0]  issue_cnt;

    always #5 CLK = ~CLK;

    alu_input_seq #(
        .DB_CYCLES (DB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .sw_data   (sw_data),
        .op_in     (op_in),
        .btn       (btn),
        .cancel    (cancel),
        .ack       (ack),
        .a_out     (a_out),
        .b_out     (b_out),
        .aluop_out (aluop_out),
        .op_valid  (op_valid),
        .state_out (state_out),
        .issue_cnt (issue_cnt)
    );

    int checks   = 0;
    int failures = 0;

    int          m_state;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    int          m_cnt;

    typedef struct {
        logic [16:0] sa;
        logic [16:0] sb;
        logic [3:0]  op;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] widen(input logic [16:0] v);
        logic [31:0] mag;
        mag = 32'(v[15:0]);
        return v[16] ? (32'hFFFF_0000 | mag) : mag;
    endfunction

    task automatic m_reset();
        m_state = 0;
        m_a = 32'd0;
        m_b = 32'd0;
        m_op = 4'd0;
        m_cnt = 0;
    endtask

    task automatic m_press(input logic [16:0] sw, input logic [3:0] op);
        if (m_state == 0) begin
            m_a = widen(sw);
            m_state = 1;
        end else if (m_state == 1) begin
            m_b = widen(sw);
            m_op = op;
            m_state = 2;
        end
    endtask

    task automatic m_ack();
        if (m_state == 2) begin
            m_cnt = (m_cnt + 1) % 256;
            m_state = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".a_out"}, a_out, m_a);
        chk({nm, ".b_out"}, b_out, m_b);
        chk({nm, ".aluop"}, 32'(aluop_out), 32'(m_op));
        chk({nm, ".state"}, 32'(state_out), 32'(m_state));
        chk({nm, ".valid"}, 32'(op_valid), 32'(m_state == 2));
        chk({nm, ".cnt"}, 32'(issue_cnt), 32'(m_cnt));
    endtask

    task automatic do_press(input logic [16:0] sw, input logic [3:0] op);
        sw_data = sw;
        op_in = aluop_t'(op);
        btn = 1'b1;
        tick(HOLD);
        btn = 1'b0;
        tick(REL);
        m_press(sw, op);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        m_ack();
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        m_state = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        m_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{17'h1_FFFE, 17'h0_0003, 4'd0, 32'hFFFF_FFFE, 32'h0000_0003};
        vecs[1] = '{17'h1_0000, 17'h0_FFFF, 4'd1, 32'hFFFF_0000, 32'h0000_FFFF};
        vecs[2] = '{17'h1_FFFF, 17'h0_0000, 4'd4, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{17'h0_8000, 17'h1_8000, 4'd7, 32'h0000_8000, 32'hFFFF_8000};
        vecs[4] = '{17'h0_1234, 17'h1_00FF, 4'd9, 32'h0000_1234, 32'hFFFF_00FF};
        vecs[5] = '{17'h1_7FFF, 17'h0_7FFF, 4'd5, 32'hFFFF_7FFF, 32'h0000_7FFF};

        RST = 1'b1;
        btn = 1'b0;
        cancel = 1'b0;
        ack = 1'b0;
        sw_data = '0;
        op_in = ALU_ADD;
        tick(3);
        RST = 1'b0;
        m_reset();

        chk("reset.a_out", a_out, 32'd0);
        chk("reset.b_out", b_out, 32'd0);
        chk("reset.aluop", 32'(aluop_out), 32'd0);
        chk("reset.valid", 32'(op_valid), 32'd0);
        chk("reset.state", 32'(state_out), 32'd0);
        chk("reset.cnt", 32'(issue_cnt), 32'd0);

`ifdef ALU_SEQ_DEBOUNCE_EN
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(12);
        chk("glitch.state", 32'(state_out), 32'd0);
`endif

        // Long hold: one press, landing exactly LAT edges after btn is first sampled high.
        sw_data = 17'h0_1234;
        btn = 1'b1;
        tick(LAT);
        chk("latency.before", 32'(state_out), 32'd0);
        tick(1);
        chk("latency.at", 32'(state_out), 32'd1);
        tick(40 - LAT - 1);
        btn = 1'b0;
        tick(REL);
        m_press(17'h0_1234, 4'd0);
        check_model("held40");

        pulse_cancel();
        check_model("cancel_in_b");

        for (int i = 0; i < 6; i++) begin
            do_press(vecs[i].sa, 4'd0);
            do_press(vecs[i].sb, vecs[i].op);
            chk($sformatf("vec%0d.a_out", i), a_out, vecs[i].ea);
            chk($sformatf("vec%0d.b_out", i), b_out, vecs[i].eb);
            chk($sformatf("vec%0d.aluop", i), 32'(aluop_out), 32'(vecs[i].op));
            chk($sformatf("vec%0d.state", i), 32'(state_out), 32'd2);
            chk($sformatf("vec%0d.valid", i), 32'(op_valid), 32'd1);
            pulse_ack();
            chk($sformatf("vec%0d.cnt", i), 32'(issue_cnt), 32'(i + 1));
            check_model($sformatf("vec%0d.post_ack", i));
        end

        // Held ISSUE: presses and waiting must not disturb the operands.
        do_reset();
        do_press(17'h0_0055, 4'd0);
        do_press(17'h1_8000, 4'd1);
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_model($sformatf("issue_hold%0d", i));
        end
        btn = 1'b0;
        tick(REL);
        check_model("issue_after_press");
        pulse_ack();
        chk("ack.cnt", 32'(issue_cnt), 32'd1);
        chk("ack.valid", 32'(op_valid), 32'd0);
        chk("ack.state", 32'(state_out), 32'd0);
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_model("ack_outside_issue");

        // cancel + ack together in ISSUE.
        do_press(17'h1_0001, 4'd0);
        do_press(17'h0_0002, 4'd3);
        cancel = 1'b1;
        ack = 1'b1;
        tick(1);
        cancel = 1'b0;
        ack = 1'b0;
        m_state = 0;
        check_model("cancel_ack");

        // cancel coincident with the press that would load B.
        do_press(17'h0_0777, 4'd0);
        sw_data = 17'h1_4444;
        op_in = ALU_OR;
        btn = 1'b1;
        tick(LAT);
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        m_state = 0;
        check_model("cancel_press");
        tick(5);
        btn = 1'b0;
        tick(REL);
        check_model("cancel_press_no_late");

        // Reset while in ISSUE, then reset mid-debounce.
        do_press(17'h0_0010, 4'd0);
        do_press(17'h0_0020, 4'd2);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        m_reset();
        check_model("reset_in_issue");
        sw_data = 17'h0_0ABC;
        btn = 1'b1;
        tick(2);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        m_reset();
        tick(LAT);
        chk("reset_db.before", 32'(state_out), 32'd0);
        tick(1);
        chk("reset_db.at", 32'(state_out), 32'd1);
        btn = 1'b0;
        tick(REL);
        m_press(17'h0_0ABC, 4'd0);
        check_model("reset_db");

        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                do_press(17'($urandom), 4'($urandom_range(0, 9)));
            end else if (r <= 7) begin
                pulse_ack();
                tick(1);
            end else if (r == 8) begin
                pulse_cancel();
                tick(1);
            end else begin
                tick(3);
            end
            check_model($sformatf("rand%0d", i));
        end

        do_reset();
        for (int i = 0; i < 256; i++) begin
            do_press(17'(i), 4'd0);
            do_press(17'(i + 1), 4'd0);
            pulse_ack();
        end
        chk("wrap256.cnt", 32'(issue_cnt), 32'd0);
        check_model("wrap256");
        do_press(17'h0_0001, 4'd0);
        do_press(17'h0_0002, 4'd0);
        pulse_ack();
        chk("wrap257.cnt", 32'(issue_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
